// File: rtl/radio_timing_pkg.sv
// Shared types and defaults for the radio timing sequencer.
package radio_timing_pkg;

  // Default counter width and reset values of the timing configuration
  localparam int CNT_W        = 4;
  localparam int DEF_WARMUP   = 2;
  localparam int DEF_COOLDOWN = 1;

  // Per-channel sequencing states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_COOLDOWN = 2'd3
  } ch_state_e;

endpackage

// File: rtl/radio_ch_seq.sv
// One radio channel: warm-up / active / cool-down sequencing of the
// radio enable and receive enable, with registered outputs.
module radio_ch_seq #(
  parameter int CNT_W = radio_timing_pkg::CNT_W
) (
  input  logic             ck,
  input  logic             arst_n,
  input  logic             en_i,
  input  logic             rx_i,
  input  logic [CNT_W-1:0] warmup_i,
  input  logic [CNT_W-1:0] cooldown_i,
  output logic             en2_o,
  output logic             rx2_o,
  output logic             busy_o,
  output logic             rx_viol_o
);
  import radio_timing_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en2_q, en2_d;
  logic             rx2_q, rx2_d;
  logic             viol_q, viol_d;
  logic             last_cnt_s;

  // Decrement that holds at zero instead of wrapping
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v != CNT_ZERO) begin
      r = v - CNT_ONE;
    end else begin
      r = CNT_ZERO;
    end
    return r;
  endfunction

  assign last_cnt_s = (cnt_q == CNT_ONE) || (cnt_q == CNT_ZERO);

  // Next-state, counter and output decode; config is sampled only on entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          if (warmup_i == CNT_ZERO) begin
            state_d = ST_ACTIVE;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_WARMUP;
            cnt_d   = warmup_i;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WARMUP: begin
        if (!en_i) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (last_cnt_s) begin
          state_d = ST_ACTIVE;
          cnt_d   = sat_dec(cnt_q);
        end else begin
          state_d = ST_WARMUP;
          cnt_d   = sat_dec(cnt_q);
        end
      end
      ST_ACTIVE: begin
        if (!en_i) begin
          if (cooldown_i == CNT_ZERO) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_COOLDOWN;
            cnt_d   = cooldown_i;
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_COOLDOWN: begin
        if (en_i) begin
          state_d = ST_ACTIVE;
          cnt_d   = CNT_ZERO;
        end else if (last_cnt_s) begin
          state_d = ST_IDLE;
          cnt_d   = sat_dec(cnt_q);
        end else begin
          state_d = ST_COOLDOWN;
          cnt_d   = sat_dec(cnt_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
    // Receive enable only passes through while enabled and active
    en2_d  = (state_d != ST_IDLE);
    rx2_d  = (state_d == ST_ACTIVE) && rx_i && en_i;
    viol_d = rx_i && !en_i;
  end

  // State, counter and output registers
  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      en2_q   <= 1'b0;
      rx2_q   <= 1'b0;
      viol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en2_q   <= en2_d;
      rx2_q   <= rx2_d;
      viol_q  <= viol_d;
    end
  end

  assign en2_o     = en2_q;
  assign rx2_o     = rx2_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign rx_viol_o = viol_q;

endmodule

// File: rtl/radio_timing_seq.sv
// Multi-channel radio timing sequencer: input stage, shared timing
// configuration and one independent sequencer per channel.
module radio_timing_seq #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = radio_timing_pkg::CNT_W,
  parameter int DEF_WARMUP   = radio_timing_pkg::DEF_WARMUP,
  parameter int DEF_COOLDOWN = radio_timing_pkg::DEF_COOLDOWN
) (
  input  logic              ck,
  input  logic              arst_n,
  input  logic              cfg_we,
  input  logic [CNT_W-1:0]  cfg_warmup,
  input  logic [CNT_W-1:0]  cfg_cooldown,
  input  logic [NUM_CH-1:0] radioEnable1,
  input  logic [NUM_CH-1:0] radioRxEn1,
  output logic [NUM_CH-1:0] radioEnable2,
  output logic [NUM_CH-1:0] radioRxEn2,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] rx_viol
);
  import radio_timing_pkg::*;

  logic [NUM_CH-1:0] en_q, rx_q;
  logic [CNT_W-1:0]  warmup_q, cooldown_q;

  // Single register stage on the request inputs
  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      en_q <= {NUM_CH{1'b0}};
      rx_q <= {NUM_CH{1'b0}};
    end else begin
      en_q <= radioEnable1;
      rx_q <= radioRxEn1;
    end
  end

  // Timing configuration, returning to defaults on reset
  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      warmup_q   <= CNT_W'(DEF_WARMUP);
      cooldown_q <= CNT_W'(DEF_COOLDOWN);
    end else if (cfg_we) begin
      warmup_q   <= cfg_warmup;
      cooldown_q <= cfg_cooldown;
    end else begin
      warmup_q   <= warmup_q;
      cooldown_q <= cooldown_q;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    radio_ch_seq #(
      .CNT_W (CNT_W)
    ) u_ch (
      .ck         (ck),
      .arst_n     (arst_n),
      .en_i       (en_q[g]),
      .rx_i       (rx_q[g]),
      .warmup_i   (warmup_q),
      .cooldown_i (cooldown_q),
      .en2_o      (radioEnable2[g]),
      .rx2_o      (radioRxEn2[g]),
      .busy_o     (busy[g]),
      .rx_viol_o  (rx_viol[g])
    );
  end

endmodule

// File: tb/tb_radio_timing_seq.sv
// Directed self-checking bench for radio_timing_seq (NUM_CH=2, CNT_W=4).
// Edge numbering below: edge 0 is the edge that first samples a request.
module tb_radio_timing_seq;

  logic       ck = 1'b0;
  logic       arst_n;
  logic       cfg_we;
  logic [3:0] cfg_warmup, cfg_cooldown;
  logic [1:0] en1, rx1, en2, rx2, busy, viol;

  int n_chk = 0;
  int n_err = 0;

  always #5 ck = ~ck;

  radio_timing_seq #(
    .NUM_CH       (2),
    .CNT_W        (4),
    .DEF_WARMUP   (2),
    .DEF_COOLDOWN (1)
  ) dut (
    .ck           (ck),
    .arst_n       (arst_n),
    .cfg_we       (cfg_we),
    .cfg_warmup   (cfg_warmup),
    .cfg_cooldown (cfg_cooldown),
    .radioEnable1 (en1),
    .radioRxEn1   (rx1),
    .radioEnable2 (en2),
    .radioRxEn2   (rx2),
    .busy         (busy),
    .rx_viol      (viol)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic cfg(input logic [3:0] w, input logic [3:0] c);
    cfg_we = 1'b1; cfg_warmup = w; cfg_cooldown = c;
    step(1);
    cfg_we = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0; cfg_we = 1'b0; cfg_warmup = 4'd0; cfg_cooldown = 4'd0;
    en1 = 2'b00; rx1 = 2'b00;
    #3;
    chk("rst_en2", en2, 2'b00);
    chk("rst_rx2", rx2, 2'b00);
    chk("rst_busy", busy, 2'b00);
    chk("rst_viol", viol, 2'b00);
    step(2);
    arst_n = 1'b1;
    step(1);

    // Warm-up 3 / cool-down 2 on channel 0; cfg write mid-warm-up ignored
    cfg(4'd3, 4'd2);
    en1 = 2'b01; rx1 = 2'b01;
    step(1);                              // edge 0
    chk("a_e0_en2", en2, 2'b00);
    step(1);                              // edge 1
    chk("a_e1_en2", en2, 2'b01);
    chk("a_e1_rx2", rx2, 2'b00);
    chk("a_e1_busy", busy, 2'b01);
    cfg_we = 1'b1; cfg_warmup = 4'd9; cfg_cooldown = 4'd2;
    step(1);                              // edge 2
    cfg_we = 1'b0;
    chk("a_e2_rx2", rx2, 2'b00);
    step(1);                              // edge 3
    chk("a_e3_rx2", rx2, 2'b00);
    step(1);                              // edge 4
    chk("a_e4_rx2", rx2, 2'b01);
    chk("a_e4_en2", en2, 2'b01);
    en1 = 2'b00; rx1 = 2'b00;
    step(1);                              // edge k
    chk("a_k_rx2", rx2, 2'b01);
    step(1);                              // k+1
    chk("a_k1_rx2", rx2, 2'b00);
    chk("a_k1_en2", en2, 2'b01);
    step(1);                              // k+2
    chk("a_k2_en2", en2, 2'b01);
    chk("a_k2_busy", busy, 2'b01);
    step(1);                              // k+3
    chk("a_k3_en2", en2, 2'b00);
    chk("a_k3_busy", busy, 2'b00);

    // Re-enable during the first cool-down cycle: straight back to ACTIVE
    cfg(4'd3, 4'd2);
    en1 = 2'b01; rx1 = 2'b00;
    step(5);                              // edge 4: ACTIVE
    chk("d_act_busy", busy, 2'b01);
    chk("d_act_en2", en2, 2'b01);
    en1 = 2'b00;
    step(1);                              // edge k
    step(1);                              // k+1: COOLDOWN cycle 1
    chk("d_k1_en2", en2, 2'b01);
    chk("d_k1_rx2", rx2, 2'b00);
    en1 = 2'b01; rx1 = 2'b01;
    step(1);                              // k+2
    chk("d_k2_en2", en2, 2'b01);
    chk("d_k2_rx2", rx2, 2'b00);
    step(1);                              // k+3: ACTIVE without warm-up
    chk("d_k3_en2", en2, 2'b01);
    chk("d_k3_rx2", rx2, 2'b01);
    en1 = 2'b00; rx1 = 2'b00;
    step(5);
    chk("d_end_en2", en2, 2'b00);
    chk("d_end_busy", busy, 2'b00);

    // Zero warm-up and cool-down on channel 1: pure 2-edge pass-through
    cfg(4'd0, 4'd0);
    en1 = 2'b10; rx1 = 2'b10;
    step(1);                              // edge 0
    chk("c_e0_en2", en2, 2'b00);
    step(1);                              // edge 1
    chk("c_e1_en2", en2, 2'b10);
    chk("c_e1_rx2", rx2, 2'b10);
    chk("c_e1_busy", busy, 2'b10);
    en1 = 2'b00; rx1 = 2'b00;
    step(1);                              // edge k
    chk("c_k_en2", en2, 2'b10);
    step(1);                              // k+1
    chk("c_k1_en2", en2, 2'b00);
    chk("c_k1_rx2", rx2, 2'b00);
    chk("c_k1_busy", busy, 2'b00);

    // Receive request without enable on channel 1 only
    en1 = 2'b00; rx1 = 2'b10;
    step(1);                              // edge 0
    chk("e_e0_viol", viol, 2'b00);
    step(1);                              // edge 1
    chk("e_e1_viol", viol, 2'b10);
    chk("e_e1_rx2", rx2, 2'b00);
    chk("e_e1_en2", en2, 2'b00);
    step(1);                              // edge 2
    chk("e_e2_viol", viol, 2'b10);
    rx1 = 2'b00;
    step(1);                              // edge 3
    chk("e_e3_viol", viol, 2'b10);
    step(1);                              // edge 4
    chk("e_e4_viol", viol, 2'b00);

    // Reset mid-warm-up while a cfg write is pending
    cfg(4'd3, 4'd2);
    en1 = 2'b01; rx1 = 2'b01;
    step(2);                              // edge 1: WARMUP
    chk("f_wu_en2", en2, 2'b01);
    cfg_we = 1'b1; cfg_warmup = 4'd7; cfg_cooldown = 4'd7;
    arst_n = 1'b0;
    #1;
    chk("f_rst_en2", en2, 2'b00);
    chk("f_rst_rx2", rx2, 2'b00);
    chk("f_rst_busy", busy, 2'b00);
    step(1);
    chk("f_hold_en2", en2, 2'b00);
    arst_n = 1'b1; cfg_we = 1'b0;
    step(1);                              // edge 0
    chk("f_e0_en2", en2, 2'b00);
    step(1);                              // edge 1
    chk("f_e1_en2", en2, 2'b01);
    step(1);                              // edge 2
    chk("f_e2_rx2", rx2, 2'b00);
    step(1);                              // edge 3: default warm-up of 2 done
    chk("f_e3_rx2", rx2, 2'b01);
    en1 = 2'b00; rx1 = 2'b00;
    step(1);                              // edge k
    chk("f_k_en2", en2, 2'b01);
    step(1);                              // k+1: default cool-down of 1
    chk("f_k1_en2", en2, 2'b01);
    chk("f_k1_rx2", rx2, 2'b00);
    step(1);                              // k+2
    chk("f_k2_en2", en2, 2'b00);
    chk("f_k2_busy", busy, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/radio_timing_seq.md
RADIO_TIMING_SEQ -- requirements
Module: radio_timing_seq

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent radio channels.
REQ-002 Parameter CNT_W, default 4: width of the warm-up and cool-down counters.
REQ-003 Parameter DEF_WARMUP, default 2: reset value of the warm-up configuration.
REQ-004 Parameter DEF_COOLDOWN, default 1: reset value of the cool-down configuration.
REQ-005 Port ck, input, 1: single clock; all state updates on rising edge.
REQ-006 Port arst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port cfg_we, input, 1: load cfg_warmup/cfg_cooldown into the config registers.
REQ-008 Port cfg_warmup, input, CNT_W: cycles radioEnable2 is high before radioRxEn2 may assert.
REQ-009 Port cfg_cooldown, input, CNT_W: cycles radioEnable2 stays high after the enable request drops.
REQ-010 Port radioEnable1, input, NUM_CH: per-channel radio enable request.
REQ-011 Port radioRxEn1, input, NUM_CH: per-channel receive-enable request.
REQ-012 Port radioEnable2, output, NUM_CH: sequenced radio enable, registered.
REQ-013 Port radioRxEn2, output, NUM_CH: sequenced receive enable, registered.
REQ-014 Port busy, output, NUM_CH: channel FSM is not in IDLE.
REQ-015 Port rx_viol, output, NUM_CH: one-cycle pulse when radioRxEn1 is high while radioEnable1 is low.

Function
REQ-016 The block SHALL register radioEnable1 and radioRxEn1 in one input stage (en_q, rx_q) before the FSM samples them.
REQ-017 Each channel SHALL run its own FSM with states IDLE, WARMUP, ACTIVE and COOLDOWN; there is no cross-channel interaction.
REQ-018 IDLE: outputs are en2=0, rx2=0. When en_q=1, the FSM SHALL go to WARMUP and load the counter with the warm-up value; if the warm-up value is 0 it SHALL go directly to ACTIVE.
REQ-019 WARMUP: outputs are en2=1, rx2=0. The counter SHALL decrement each cycle, and the FSM SHALL enter ACTIVE after exactly warm-up cycles in WARMUP. If en_q=0, the FSM SHALL return to IDLE with no cool-down.
REQ-020 ACTIVE: outputs are en2=1, rx2=rx_q. When en_q=0, the FSM SHALL go to COOLDOWN and load the counter with the cool-down value (or go to IDLE if the value is 0), and rx2 SHALL drop on that same edge.
REQ-021 COOLDOWN: outputs are en2=1, rx2=0. The FSM SHALL go to IDLE after exactly cool-down cycles; if en_q=1 during COOLDOWN, it SHALL re-enter ACTIVE without a new warm-up.
REQ-022 Outputs SHALL be registered from the next-state value, so radioEnable2 rises on the second rising edge after radioEnable1 is first sampled high.
REQ-023 The counter SHALL saturate at 0 and SHALL never wrap.
REQ-024 Config registers SHALL be copied into a channel counter only on WARMUP or COOLDOWN entry. A cfg_we during a count SHALL NOT alter the running count.
REQ-025 rx_viol SHALL pulse for one cycle per cycle in which rx_q=1 and en_q=0, and radioRxEn2 SHALL remain 0 in that case.

Reset
REQ-026 While arst_n=0, the block SHALL immediately force every channel to IDLE and clear en_q, rx_q, radioEnable2, radioRxEn2, busy, rx_viol and the counters to 0.
REQ-027 Reset SHALL set the config registers to DEF_WARMUP and DEF_COOLDOWN.
REQ-028 A reset asserted mid-WARMUP, mid-ACTIVE or mid-COOLDOWN SHALL abort the sequence with no cool-down.

Structure
REQ-029 Package radio_timing_pkg SHALL hold the FSM state enum, the default CNT_W, and the DEF_WARMUP and DEF_COOLDOWN constants.
REQ-030 Per-channel logic SHALL be sub-module radio_ch_seq, instantiated NUM_CH times in a generate loop.
REQ-031 The top level SHALL contain only the input stage, the config registers and the instances.

Verification
REQ-032 warmup=3, cooldown=2; en1=rx1=1 sampled at edge 0 -> en2=1 from edge 1; rx2=1 from edge 4.
REQ-033 From ACTIVE, en1 falls (sampled at edge k) -> rx2=0 at edge k+1; en2=0 at edge k+3; busy=0 at edge k+3.
REQ-034 warmup=0, cooldown=0 -> en2 and rx2 follow en1 and rx1 with a 2-edge latency and no extra cycles.
REQ-035 en1 re-asserted during cycle 1 of COOLDOWN -> ACTIVE on the next edge, en2 never drops, no WARMUP.
REQ-036 rx1=1 with en1=0 on channel 1 only -> rx_viol[1] pulses each cycle, rx2[1]=0, channel 0 unaffected.
REQ-037 arst_n pulsed low mid-WARMUP while cfg_we writes warmup=7 -> outputs 0 immediately; after release, warmup=DEF_WARMUP.
